// File: rtl/int_ctrl_if.sv
// ----------------------------------------------------------------------------
// int_ctrl_if
// Word-addressed register bus between the Bridge and the interrupt controller.
//   Addr [31:2] : word address (controller decodes Addr[4:2] only)
//   WE          : one-cycle write strobe, asserted only when the block is selected
//   Din  [31:0] : write data (controller uses bits [5:0])
//   Dout [31:0] : combinational read data
// Modports: master = Bridge side, slave = controller side.
// ----------------------------------------------------------------------------
interface int_ctrl_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/int_ctrl.sv
// ----------------------------------------------------------------------------
// int_ctrl
// Memory-mapped interrupt controller feeding the CPU's HWInt[5:0] input.
// Six request lines are latched as edge- or level-sensitive PENDING bits,
// masked by software, and presented with a priority-encoded source index.
//
// Ports:
//   clk      : system clock (single domain)
//   reset    : synchronous, active-high reset
//   bus      : int_ctrl_if.slave register bus (Addr/WE/Din/Dout)
//   irq_src  : request lines (0 Timer0, 1 Timer1, 2 external, 3..5 spare)
//   HWInt    : PENDING & MASK
//   irq_any  : OR of HWInt
//   irq_id   : index of lowest set HWInt bit, 7 when none
//
// Register map (word offset Addr[4:2]):
//   0 PENDING (R, W1C on edge bits)  1 MASK (RW)  2 MODE (RW, 1 = edge)
//   3 RAW (RO)  4 FORCE (WO, reads 0)  5..7 read 0
//
// Configuration macro INT_CTRL_EDGE_EN:
//   defined   - edge detection, src_q, W1C clearing and FORCE are built.
//   undefined - every source is level-sensitive; MODE reads 0, MODE/PENDING/
//               FORCE writes are ignored; RESET_MODE is unused.
// ----------------------------------------------------------------------------
module int_ctrl #(
    parameter logic [5:0] RESET_MASK = 6'b000111,
    parameter logic [5:0] RESET_MODE = 6'b000011
) (
    input  logic             clk,
    input  logic             reset,
    int_ctrl_if.slave        bus,
    input  logic [5:0]       irq_src,
    output logic [5:0]       HWInt,
    output logic             irq_any,
    output logic [2:0]       irq_id
);

    logic [2:0] offset;
    logic       wr_mask;
    logic [5:0] pend_q, pend_d;
    logic [5:0] mask_q;
    logic [5:0] mode_rd;

    assign offset  = bus.Addr[4:2];
    assign wr_mask = bus.WE && (offset == 3'd1);

`ifdef INT_CTRL_EDGE_EN
    logic       wr_pend, wr_mode, wr_force;
    logic [5:0] mode_q, src_q;
    logic [5:0] edge_set, edge_clr;

    assign wr_pend  = bus.WE && (offset == 3'd0);
    assign wr_mode  = bus.WE && (offset == 3'd2);
    assign wr_force = bus.WE && (offset == 3'd4);

    // Set terms are OR-ed in after the clear so a simultaneous set wins.
    assign edge_set = (irq_src & ~src_q) | ({6{wr_force}} & bus.Din[5:0]);
    assign edge_clr = {6{wr_pend}} & bus.Din[5:0];
    assign pend_d   = (mode_q & ((pend_q & ~edge_clr) | edge_set))
                    | (~mode_q & irq_src);
    assign mode_rd  = mode_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= RESET_MODE;
            src_q  <= '0;
        end else begin
            src_q <= irq_src;
            if (wr_mode) begin
                mode_q <= bus.Din[5:0];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.Addr[31:5], bus.Din[31:6]};
`else
    // Every source is level-sensitive: PENDING simply tracks the inputs.
    assign pend_d  = irq_src;
    assign mode_rd = '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.Addr[31:5], bus.Din[31:6], RESET_MODE};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            mask_q <= RESET_MASK;
        end else begin
            pend_q <= pend_d;
            if (wr_mask) begin
                mask_q <= bus.Din[5:0];
            end
        end
    end

    assign HWInt   = pend_q & mask_q;
    assign irq_any = |HWInt;

    // Scan from the top so the lowest set bit (highest priority) wins.
    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        irq_id = 3'd7;
        for (int i = 5; i >= 0; i--) begin
            if (HWInt[i]) begin
                irq_id = 3'(i);
            end
        end
    end

    always_comb begin
        bus.Dout = '0;
        case (offset)
            3'd0:    bus.Dout[5:0] = pend_q;
            3'd1:    bus.Dout[5:0] = mask_q;
            3'd2:    bus.Dout[5:0] = mode_rd;
            3'd3:    bus.Dout[5:0] = irq_src;
            default: bus.Dout      = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// ----------------------------------------------------------------------------
// tb_int_ctrl
// Directed self-checking bench for int_ctrl. Inputs change 1 ns after each
// rising clock edge; outputs are compared in that same quiet window.
// Edge-mode scenarios are built only when INT_CTRL_EDGE_EN is defined;
// otherwise the level-only behaviour of the default build is checked.
// ----------------------------------------------------------------------------
module tb_int_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] irq_src;
    logic [5:0] HWInt;
    logic       irq_any;
    logic [2:0] irq_id;

    int n_checks;
    int n_pass;

    int_ctrl_if bus ();

    int_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq_src (irq_src),
        .HWInt   (HWInt),
        .irq_any (irq_any),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        bus.Addr = {27'd0, off};
        bus.Din  = data;
        bus.WE   = 1'b1;
        tick();
        bus.WE   = 1'b0;
        bus.Din  = '0;
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
        bus.Addr = {27'd0, off};
        #1;
        check(tag, bus.Dout, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        irq_src  = '0;
        bus.Addr = '0;
        bus.WE   = 1'b0;
        bus.Din  = '0;

        // Reset and defaults
        tick();
        tick();
        reset = 1'b0;
        rd("rst_mask", 3'd1, 32'h7);
`ifdef INT_CTRL_EDGE_EN
        rd("rst_mode", 3'd2, 32'h3);
`else
        rd("rst_mode", 3'd2, 32'h0);
`endif
        rd("rst_pend", 3'd0, 32'h0);
        check("rst_hwint", {26'd0, HWInt}, 32'h0);
        check("rst_id", {29'd0, irq_id}, 32'd7);
        check("rst_any", {31'd0, irq_any}, 32'd0);

`ifdef INT_CTRL_EDGE_EN
        // Timer0 edge pulse: latched one cycle later and held
        irq_src = 6'h01;
        check("t0_before", {26'd0, HWInt}, 32'h0);
        tick();
        irq_src = 6'h00;
        check("t0_set", {26'd0, HWInt}, 32'h1);
        check("t0_id", {29'd0, irq_id}, 32'd0);
        tick();
        check("t0_held", {26'd0, HWInt}, 32'h1);
        wr(3'd0, 32'h1);
        check("t0_w1c", {26'd0, HWInt}, 32'h0);

        // Set beats clear on Timer1
        irq_src = 6'h02;
        wr(3'd0, 32'h2);
        rd("set_wins", 3'd0, 32'h2);
        check("set_wins_id", {29'd0, irq_id}, 32'd1);
        wr(3'd0, 32'h2);
        rd("t1_clr", 3'd0, 32'h0);
        tick();
        tick();
        rd("t1_held_high", 3'd0, 32'h0);
        irq_src = 6'h00;
        tick();
`else
        // Level-only build: a one-cycle pulse shows for exactly one cycle
        irq_src = 6'h01;
        tick();
        irq_src = 6'h00;
        check("t0_lvl_set", {26'd0, HWInt}, 32'h1);
        tick();
        check("t0_lvl_drop", {26'd0, HWInt}, 32'h0);
`endif

        // Level follows source for exactly three cycles; W1C has no effect
        irq_src = 6'h04;
        check("lvl_delay", {26'd0, HWInt}, 32'h0);
        tick();
        check("lvl_c1", {26'd0, HWInt}, 32'h4);
        wr(3'd0, 32'h4);
        check("lvl_c2_w1c", {26'd0, HWInt}, 32'h4);
        tick();
        check("lvl_c3", {26'd0, HWInt}, 32'h4);
        check("lvl_id", {29'd0, irq_id}, 32'd2);
        irq_src = 6'h00;
        tick();
        check("lvl_off", {26'd0, HWInt}, 32'h0);
        check("lvl_any_off", {31'd0, irq_any}, 32'd0);

        // Mask and priority: masked bit still pending, unmask takes effect
        wr(3'd1, 32'h4);
        irq_src = 6'h05;
        tick();
        rd("mp_pend", 3'd0, 32'h5);
        check("mp_hwint", {26'd0, HWInt}, 32'h4);
        check("mp_id2", {29'd0, irq_id}, 32'd2);
        wr(3'd1, 32'h5);
        check("mp_id0", {29'd0, irq_id}, 32'd0);
        check("mp_hwint2", {26'd0, HWInt}, 32'h5);
        irq_src = 6'h00;
        tick();
`ifdef INT_CTRL_EDGE_EN
        check("mp_edge_stays", {26'd0, HWInt}, 32'h1);
        wr(3'd0, 32'h1);
`endif
        check("mp_clear", {26'd0, HWInt}, 32'h0);
        wr(3'd1, 32'h7);

        // RAW and unmapped offsets (no clock edge while irq_src is set)
        irq_src = 6'h2A;
        rd("raw", 3'd3, 32'h2A);
        rd("off5", 3'd5, 32'h0);
        rd("off7", 3'd7, 32'h0);
        irq_src = 6'h00;

`ifdef INT_CTRL_EDGE_EN
        // FORCE sets an edge bit; ignored on a level bit; reads 0
        wr(3'd4, 32'h9);
        rd("force_pend", 3'd0, 32'h1);
        rd("force_rd0", 3'd4, 32'h0);

        // Edge -> level: keeps value through the write edge, then follows input
        wr(3'd2, 32'h2);
        rd("e2l_write", 3'd0, 32'h1);
        tick();
        rd("e2l_follow", 3'd0, 32'h0);

        // Level -> edge: current value kept until W1C
        irq_src = 6'h04;
        tick();
        wr(3'd2, 32'h6);
        irq_src = 6'h00;
        tick();
        rd("l2e_keep", 3'd0, 32'h4);
        wr(3'd0, 32'h4);
        rd("l2e_w1c", 3'd0, 32'h0);
`else
        // FORCE and MODE writes are ignored in the level-only build
        wr(3'd4, 32'h1);
        tick();
        rd("force_ignored", 3'd0, 32'h0);
        wr(3'd2, 32'h3F);
        rd("mode_reads0", 3'd2, 32'h0);
`endif

        // Reset wins over a concurrent MASK write
        irq_src  = 6'h04;
        tick();
        reset    = 1'b1;
        wr(3'd1, 32'h3F);
        reset    = 1'b0;
        irq_src  = 6'h00;
        rd("rstw_mask", 3'd1, 32'h7);
        rd("rstw_pend", 3'd0, 32'h0);
        check("rstw_id", {29'd0, irq_id}, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller between the timer/external IRQ sources and the CPU's `HWInt[5:0]` input. It samples up to six request lines (Timer0, Timer1, external interrupt, three spare) and latches them as edge- or level-sensitive pending bits. It applies a software mask and presents the result, plus a priority-encoded source index, to the CPU. Software accesses it through the Bridge like a TC: word registers on a 30-bit word address, with write enable and 32-bit data in and out.

## Interface
- `RESET_MASK`, default `6'b000111`: MASK value after reset (Timer0, Timer1, external enabled).
- `RESET_MODE`, default `6'b000011`: MODE value after reset (timers edge, external level).
- `clk` in 1: system clock. Single clock domain; the reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `Addr` in 30 (`[31:2]`): word address. Only `Addr[4:2]` is decoded; the Bridge asserts `WE` only when this block is selected.
- `WE` in 1: write strobe, one cycle per write.
- `Din` in 32: write data. Bits [5:0] are used; others are ignored.
- `Dout` out 32: combinational read data for `Addr[4:2]`; bits [31:6] are always 0.
- `irq_src` in 6: request lines. Bit 0 is Timer0_IRQ, bit 1 is Timer1_IRQ, bit 2 is the external interrupt, bits 3–5 are spare (tie 0).
- `HWInt` out 6: `PENDING & MASK`, driven to the CPU.
- `irq_any` out 1: OR of `HWInt`.
- `irq_id` out 3: index of the lowest set bit of `HWInt`; 7 when none is set.

## Operation
Register map (word offset = `Addr[4:2]`):
- **0 PENDING** (read; write-1-to-clear). Clearing applies to edge-mode bits only. Writes to level-mode bits are ignored.
- **1 MASK** (read/write).
- **2 MODE** (read/write). 1 = edge, 0 = level.
- **3 RAW** (read only). Current `irq_src` value.
- **4 FORCE** (write only; reads 0). Writing 1 sets the PENDING bit of an edge-mode source, as a software-triggered interrupt.
- **Offsets 5–7**: read 0, writes ignored.

Source state:
- `src_q[5:0]` registers `irq_src` every cycle.
- An **edge-mode** bit *i* sets PENDING[i] on a sampled rising edge (`irq_src[i] & ~src_q[i]`) or a FORCE write. It clears only on a PENDING write with `Din[i]=1`.
- A **level-mode** bit *i* follows the input: PENDING[i] <= `irq_src[i]` every cycle.

Priority: bit 0 is highest. `irq_id` is the index of the lowest set bit of `HWInt`.

Boundary rules:
- **Set and clear in the same cycle** on an edge-mode bit: set wins and PENDING stays 1.
- **MODE write that changes a bit from edge to level**: the bit takes the level value from the next cycle on.
- **MODE write that changes a bit from level to edge**: the bit keeps its current PENDING value until a W1C write clears it.
- **Masking**: a masked source still accumulates PENDING. Unmasking it later asserts `HWInt` immediately.
- **Held-high source in edge mode**: an `irq_src` that stays high produces exactly one set. No new set occurs until the line drops and rises again.
- **Reset** during any activity (including mid-write) takes priority over everything else in that cycle.

## Timing
Reset values (synchronous, active-high, `clk` rising edge):
- PENDING = 0, `src_q` = 0.
- MASK = `RESET_MASK`, MODE = `RESET_MODE`.
- `HWInt` = 0, `irq_any` = 0, `irq_id` = 7.
- `Dout` = the register selected by `Addr` using these values.

Latency:
- A source rising in cycle *n* is sampled at edge *n+1*. PENDING and `HWInt` are high after edge *n+1*, so the latency is one cycle in both modes.
- A write in cycle *n* takes effect after edge *n+1*.
- `HWInt`, `irq_any` and `irq_id` are combinational from the PENDING and MASK registers: no extra stage and glitch-free relative to `clk`.
- Reads have zero latency. `Dout` changes in the same cycle as `Addr`.

## Configuration
Macro `INT_CTRL_EDGE_EN`.

Defined:
- Edge detection, the `src_q` register, W1C clearing and FORCE are built as described above.

Undefined:
- All sources are level-sensitive.
- MODE reads 0 and ignores writes; `RESET_MODE` is unused.
- FORCE and PENDING writes are ignored.
- `src_q` is not instantiated.

## Test plan
- **Reset and defaults**: hold reset 2 cycles, release. Expect MASK reads `0x7`, MODE reads `0x3`, PENDING reads `0`, `HWInt = 0`, `irq_id = 7`.
- **Timer0 edge**: pulse `irq_src[0]` for 1 cycle. Expect `HWInt = 6'b000001` one cycle later, held after the pulse ends. Write `0x1` to offset 0; expect `HWInt = 0` after the next edge.
- **Set beats clear**: rising edge on `irq_src[1]` in the same cycle as a W1C write of `0x2`. Expect PENDING[1] = 1 afterwards.
- **Level follows source**: raise `irq_src[2]` for 3 cycles. Expect `HWInt[2]` high for exactly 3 cycles, delayed by 1. A W1C write of `0x4` has no effect.
- **Mask and priority**: sources 0 and 2 both pending with MASK = `0x4` → `irq_id = 2`. Write MASK = `0x5` → `irq_id = 0` after the next edge.
- **Macro off**: with `INT_CTRL_EDGE_EN` undefined, write FORCE `0x1`. Expect PENDING stays 0 and MODE reads 0.
